// File: rtl/bus_dma_copy_pkg.sv
// Shared types for the DMA copy engine and the on-chip bus it masters.
// Address and data are 8 bits; address arithmetic wraps modulo 256.
package bus_dma_copy_pkg;

   typedef logic [7:0] addr_t;
   typedef logic [7:0] rdata_t;
   typedef logic [7:0] wdata_t;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_WAIT_GNT,
      DMA_READ,
      DMA_READ_WAIT,
      DMA_WRITE,
      DMA_PAUSE,
      DMA_DONE
   } dma_state_t;

   function automatic addr_t addr_at(input addr_t base, input logic [7:0] idx);
      return base + idx;
   endfunction

endpackage

// File: rtl/bus_dma_copy_intf.sv
// Arbitrated on-chip bus as seen by one master: request/grant plus a
// single-cycle read strobe and a single-cycle write strobe.
interface intf;
   import bus_dma_copy_pkg::*;

   logic   req;
   logic   gnt;
   addr_t  addr;
   rdata_t rdata;
   wdata_t wdata;
   logic   RE;
   logic   WE;

   modport mport (
      output req,
      output addr,
      output wdata,
      output RE,
      output WE,
      input  gnt,
      input  rdata
   );

endinterface

// File: rtl/bus_dma_copy.sv
// Bus master that copies len words from src_base to dst_base, holding the bus
// for at most MAX_BURST words per grant before releasing it for one cycle.
module bus_dma_copy
   import bus_dma_copy_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  addr_t      src_base,
   input  addr_t      dst_base,
   input  logic [7:0] len,
   output logic       busy,
   output logic       done,
   intf.mport         bus
);

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   dma_state_t state_q, state_n;
   addr_t      src_q, src_n;
   addr_t      dst_q, dst_n;
   logic [7:0] len_q, len_n;
   logic [7:0] i_q, i_n;
   logic [7:0] b_q, b_n;
   logic       req_q, req_n;
   logic       re_q, re_n;
   logic       we_q, we_n;
   addr_t      addr_q, addr_n;
   wdata_t     wdata_q, wdata_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DMA_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         i_q     <= '0;
         b_q     <= '0;
         req_q   <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_n;
         src_q   <= src_n;
         dst_q   <= dst_n;
         len_q   <= len_n;
         i_q     <= i_n;
         b_q     <= b_n;
         req_q   <= req_n;
         re_q    <= re_n;
         we_q    <= we_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
      end
   end

   // Every bus output is computed here one cycle ahead and registered above.
   always_comb begin
      state_n = state_q;
      src_n   = src_q;
      dst_n   = dst_q;
      len_n   = len_q;
      i_n     = i_q;
      b_n     = b_q;
      req_n   = req_q;
      re_n    = re_q;
      we_n    = we_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;

      case (state_q)
         DMA_IDLE: begin
            if (start) begin
               if (len == 8'd0) begin
                  state_n = DMA_DONE;
               end else begin
                  src_n   = src_base;
                  dst_n   = dst_base;
                  len_n   = len;
                  i_n     = '0;
                  b_n     = '0;
                  req_n   = 1'b1;
                  state_n = DMA_WAIT_GNT;
               end
            end
         end
         DMA_WAIT_GNT: begin
            re_n = 1'b0;
            we_n = 1'b0;
            if (bus.gnt) begin
               re_n    = 1'b1;
               addr_n  = addr_at(src_q, i_q);
               state_n = DMA_READ;
            end
         end
         DMA_READ: begin
            re_n    = 1'b0;
            state_n = DMA_READ_WAIT;
         end
         DMA_READ_WAIT: begin
            wdata_n = bus.rdata;
            addr_n  = addr_at(dst_q, i_q);
            we_n    = 1'b1;
            state_n = DMA_WRITE;
         end
         DMA_WRITE: begin
            we_n = 1'b0;
            i_n  = i_q + 8'd1;
            b_n  = b_q + 8'd1;
            // Finishing the block takes priority over ending a burst.
            if (i_q == len_q - 8'd1) begin
               req_n   = 1'b0;
               state_n = DMA_DONE;
            end else if (b_q == BURST_LAST) begin
               req_n   = 1'b0;
               b_n     = '0;
               state_n = DMA_PAUSE;
            end else begin
               re_n    = 1'b1;
               addr_n  = addr_at(src_q, i_q + 8'd1);
               state_n = DMA_READ;
            end
         end
         DMA_PAUSE: begin
            req_n   = 1'b1;
            state_n = DMA_WAIT_GNT;
         end
         DMA_DONE: begin
            state_n = DMA_IDLE;
         end
         default: begin
            state_n = DMA_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != DMA_IDLE);
   assign done      = (state_q == DMA_DONE);
   assign bus.req   = req_q;
   assign bus.RE    = re_q;
   assign bus.WE    = we_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Randomized bench for bus_dma_copy: a parking arbiter, a second master, a flat
// 256-word memory behind the bus, and a reference model of the copied memory.
module tb_bus_dma_copy;
   import bus_dma_copy_pkg::*;

   localparam int MAX_BURST = 4;
   localparam int WAIT_LIMIT = 2000;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   addr_t      src_base;
   addr_t      dst_base;
   logic [7:0] len;
   logic       busy;
   logic       done;

   logic       other_req;
   logic       own_dma;
   logic       own_other;
   logic       parked;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];

   int total = 0;
   int bad = 0;

   int re_cnt = 0;
   int we_cnt = 0;
   int req_cnt = 0;
   int req_low_busy_cnt = 0;
   int done_cnt = 0;
   int viol_cnt = 0;
   addr_t rd_log[$];

   intf bus ();

   bus_dma_copy #(.MAX_BURST(MAX_BURST)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .src_base (src_base),
      .dst_base (dst_base),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   assign bus.gnt = own_dma;

   // Registered arbiter that parks the grant on the last owner until the other master asks.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         own_dma   <= 1'b0;
         own_other <= 1'b0;
      end else if (own_dma) begin
         if (!bus.req && other_req) begin
            own_dma   <= 1'b0;
            own_other <= 1'b1;
         end
      end else if (own_other) begin
         if (!other_req && bus.req) begin
            own_other <= 1'b0;
            own_dma   <= 1'b1;
         end
      end else if (other_req) begin
         own_other <= 1'b1;
      end else if (bus.req) begin
         own_dma <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (own_dma && bus.RE) bus.rdata <= mem[bus.addr];
      if (own_dma && bus.WE) mem[bus.addr] = bus.wdata;
   end

   always @(negedge clk) begin
      if (bus.RE) begin
         re_cnt++;
         rd_log.push_back(bus.addr);
      end
      if (bus.WE) we_cnt++;
      if (bus.req) req_cnt++;
      if (busy && !bus.req) req_low_busy_cnt++;
      if (done) done_cnt++;
      if ((bus.RE && bus.WE) || (bus.RE && !bus.gnt) || (bus.WE && !bus.gnt)) viol_cnt++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int exp_done(input int n, input logic pk);
      if (n == 0) return 0;
      return (pk ? 1 : 2) + 3 * n + 2 * ((n - 1) / MAX_BURST);
   endfunction

   function automatic void model_copy(input addr_t s, input addr_t d, input int n);
      for (int k = 0; k < n; k++) begin
         ref_mem[8'(d + 8'(k))] = ref_mem[8'(s + 8'(k))];
      end
   endfunction

   function automatic int mem_diffs(output int first_idx);
      int n = 0;
      first_idx = -1;
      for (int k = 0; k < 256; k++) begin
         if (mem[k] !== ref_mem[k]) begin
            if (first_idx < 0) first_idx = k;
            n++;
         end
      end
      return n;
   endfunction

   task automatic fill_mem();
      for (int k = 0; k < 256; k++) begin
         mem[k] = 8'($urandom);
         ref_mem[k] = mem[k];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      parked = 1'b0;
   endtask

   task automatic start_copy(input addr_t s, input addr_t d, input logic [7:0] n);
      @(negedge clk);
      start    = 1'b1;
      src_base = s;
      dst_base = d;
      len      = n;
      @(posedge clk);
      #1;
      start    = 1'b0;
      src_base = 8'($urandom);
      dst_base = 8'($urandom);
      len      = 8'($urandom);
   endtask

   task automatic wait_done(output int cyc, output int busy_gaps);
      cyc = 0;
      busy_gaps = 0;
      while (!done && cyc < WAIT_LIMIT) begin
         if (!busy) busy_gaps++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset();
      other_req = 1'b0;
      start = 1'b0;
      src_base = '0;
      dst_base = '0;
      len = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (bus.req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", bus.req); end
      total++;
      if (bus.RE !== 1'b0) begin bad++; $display("[TB] FAIL reset_RE: got %b want 0", bus.RE); end
      total++;
      if (bus.WE !== 1'b0) begin bad++; $display("[TB] FAIL reset_WE: got %b want 0", bus.WE); end
      total++;
      if (bus.addr !== 8'h00) begin bad++; $display("[TB] FAIL reset_addr: got %h want 00", bus.addr); end
      total++;
      if (bus.wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 00", bus.wdata); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      reset = 1'b0;
      parked = 1'b0;
   endtask

   task automatic test_short_copy();
      int cyc, gaps, nd, fi;
      fill_mem();
      mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
      ref_mem[8'h10] = 8'hA1; ref_mem[8'h11] = 8'hB2; ref_mem[8'h12] = 8'hC3;
      model_copy(8'h10, 8'h90, 3);
      start_copy(8'h10, 8'h90, 8'd3);
      wait_done(cyc, gaps);
      total++;
      if (cyc !== exp_done(3, parked)) begin bad++; $display("[TB] FAIL short_done_cycle: got %0d want %0d", cyc, exp_done(3, parked)); end
      total++;
      if (gaps !== 0) begin bad++; $display("[TB] FAIL short_busy: idle samples %0d want 0", gaps); end
      @(posedge clk); #1;
      total++;
      if ({mem[8'h90], mem[8'h91], mem[8'h92]} !== 24'hA1B2C3) begin
         bad++;
         $display("[TB] FAIL short_data: got %h%h%h want a1b2c3", mem[8'h90], mem[8'h91], mem[8'h92]);
      end
      nd = mem_diffs(fi);
      total++;
      if (nd !== 0) begin bad++; $display("[TB] FAIL short_mem: %0d words differ, first at %0d, want 0", nd, fi); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL short_idle: busy %b want 0", busy); end
      parked = 1'b1;
   endtask

   task automatic test_zero_len();
      int cyc, gaps, nd, fi, req0, re0, we0;
      req0 = req_cnt; re0 = re_cnt; we0 = we_cnt;
      start_copy(8'($urandom), 8'($urandom), 8'd0);
      wait_done(cyc, gaps);
      total++;
      if (cyc !== 0) begin bad++; $display("[TB] FAIL zero_done_cycle: got %0d want 0", cyc); end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ((req_cnt - req0) !== 0) begin bad++; $display("[TB] FAIL zero_req: req high %0d cycles want 0", req_cnt - req0); end
      total++;
      if ((re_cnt - re0) + (we_cnt - we0) !== 0) begin
         bad++;
         $display("[TB] FAIL zero_strobes: RE %0d WE %0d cycles want 0", re_cnt - re0, we_cnt - we0);
      end
      nd = mem_diffs(fi);
      total++;
      if (nd !== 0) begin bad++; $display("[TB] FAIL zero_mem: %0d words differ want 0", nd); end
   endtask

   task automatic test_burst_limit();
      int cyc, gaps, nd, fi, low0, we0;
      do_reset();
      fill_mem();
      model_copy(8'h20, 8'hA0, 6);
      low0 = req_low_busy_cnt; we0 = we_cnt;
      start_copy(8'h20, 8'hA0, 8'd6);
      wait_done(cyc, gaps);
      total++;
      if (cyc !== exp_done(6, parked)) begin bad++; $display("[TB] FAIL burst_done_cycle: got %0d want %0d", cyc, exp_done(6, parked)); end
      @(posedge clk); #1;
      total++;
      if ((req_low_busy_cnt - low0) !== 2) begin
         bad++;
         $display("[TB] FAIL burst_req_low: busy cycles with req low %0d want 2", req_low_busy_cnt - low0);
      end
      total++;
      if ((we_cnt - we0) !== 6) begin bad++; $display("[TB] FAIL burst_writes: got %0d want 6", we_cnt - we0); end
      nd = mem_diffs(fi);
      total++;
      if (nd !== 0) begin bad++; $display("[TB] FAIL burst_mem: %0d words differ, first at %0d, want 0", nd, fi); end
      parked = 1'b1;
   endtask

   task automatic test_contention();
      int cyc, gaps, nd, fi, held_bad;
      addr_t s, d;
      s = 8'h30 + 8'($urandom_range(0, 15));
      d = 8'hD0 + 8'($urandom_range(0, 15));
      @(negedge clk);
      other_req = 1'b1;
      repeat (3) @(negedge clk);
      model_copy(s, d, 3);
      start_copy(s, d, 8'd3);
      held_bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (!busy || !bus.req || bus.RE || bus.WE || bus.gnt) held_bad++;
      end
      total++;
      if (held_bad !== 0) begin bad++; $display("[TB] FAIL contention_wait: %0d bad samples want 0", held_bad); end
      other_req = 1'b0;
      wait_done(cyc, gaps);
      total++;
      if (cyc === -1) begin bad++; $display("[TB] FAIL contention_done: timed out, want done"); end
      @(posedge clk); #1;
      nd = mem_diffs(fi);
      total++;
      if (nd !== 0) begin bad++; $display("[TB] FAIL contention_mem: %0d words differ, first at %0d, want 0", nd, fi); end
      parked = 1'b1;
   endtask

   task automatic test_wrap();
      int cyc, gaps, nd, fi, base;
      logic [23:0] got;
      base = rd_log.size();
      model_copy(8'hFE, 8'h40, 3);
      start_copy(8'hFE, 8'h40, 8'd3);
      wait_done(cyc, gaps);
      total++;
      if (cyc !== exp_done(3, parked)) begin bad++; $display("[TB] FAIL wrap_done_cycle: got %0d want %0d", cyc, exp_done(3, parked)); end
      @(posedge clk); #1;
      got = 24'hxxxxxx;
      if (rd_log.size() >= base + 3) got = {rd_log[base], rd_log[base + 1], rd_log[base + 2]};
      total++;
      if (got !== 24'hFEFF00) begin bad++; $display("[TB] FAIL wrap_read_order: got %h want feff00", got); end
      nd = mem_diffs(fi);
      total++;
      if (nd !== 0) begin bad++; $display("[TB] FAIL wrap_mem: %0d words differ, first at %0d, want 0", nd, fi); end
   endtask

   task automatic test_reset_midop();
      int cyc, gaps, nd, fi, we0, done0, guard;
      logic [20:0] outs;
      model_copy(8'h08, 8'hC8, 4);
      we0 = we_cnt;
      done0 = done_cnt;
      start_copy(8'h08, 8'hC8, 8'd4);
      guard = 0;
      while ((we_cnt - we0) < 2 && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      total++;
      if ((we_cnt - we0) !== 2) begin bad++; $display("[TB] FAIL midop_reach_write: writes %0d want 2", we_cnt - we0); end
      reset = 1'b1;
      #1;
      outs = {bus.req, bus.RE, bus.WE, busy, done, bus.addr, bus.wdata};
      total++;
      if (outs !== 21'd0) begin bad++; $display("[TB] FAIL midop_reset_outputs: got %h want 0", outs); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      parked = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ((done_cnt - done0) !== 0) begin bad++; $display("[TB] FAIL midop_no_done: done seen %0d want 0", done_cnt - done0); end
      start_copy(8'h08, 8'hC8, 8'd4);
      wait_done(cyc, gaps);
      total++;
      if (cyc !== exp_done(4, parked)) begin bad++; $display("[TB] FAIL midop_restart_cycle: got %0d want %0d", cyc, exp_done(4, parked)); end
      @(posedge clk); #1;
      nd = mem_diffs(fi);
      total++;
      if (nd !== 0) begin bad++; $display("[TB] FAIL midop_mem: %0d words differ, first at %0d, want 0", nd, fi); end
      parked = 1'b1;
   endtask

   task automatic test_random_copies();
      int cyc, gaps, nd, fi, n;
      addr_t s, d;
      for (int t = 0; t < 8; t++) begin
         s = 8'($urandom);
         d = 8'($urandom);
         n = $urandom_range(0, 24);
         model_copy(s, d, n);
         start_copy(s, d, 8'(n));
         wait_done(cyc, gaps);
         total++;
         if (cyc !== exp_done(n, parked)) begin
            bad++;
            $display("[TB] FAIL random_done_cycle[%0d]: len %0d got %0d want %0d", t, n, cyc, exp_done(n, parked));
         end
         @(posedge clk); #1;
         nd = mem_diffs(fi);
         total++;
         if (nd !== 0) begin
            bad++;
            $display("[TB] FAIL random_mem[%0d]: src %h dst %h len %0d, %0d words differ want 0", t, s, d, n, nd);
         end
         if (n != 0) parked = 1'b1;
      end
   endtask

   task automatic test_bus_rules();
      total++;
      if (viol_cnt !== 0) begin bad++; $display("[TB] FAIL bus_strobe_rules: %0d bad cycles want 0", viol_cnt); end
   endtask

   initial begin
      test_reset();
      test_short_copy();
      test_zero_len();
      test_burst_limit();
      test_contention();
      test_wrap();
      test_reset_midop();
      test_random_copies();
      test_bus_rules();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_dma_copy.md
# bus_dma_copy

Bus master that copies a block of `len` words from a source address range to a destination address range on the arbitrated on-chip bus. It connects through one `intf` master modport alongside the existing masters, and the slave memories are its targets. Software or a parent block supplies base addresses and length through a start/done handshake. It holds the bus for at most `MAX_BURST` words per grant and then releases it so other masters are not starved.

## Interface
- `MAX_BURST`, default 4: words copied per bus grant; must be ≥1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- `src_base`  in  addr_t (8)  first source address; captured on accepted `start`.
- `dst_base`  in  addr_t (8)  first destination address; captured on accepted `start`.
- `len`  in  8  number of words to copy, 0..255.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the copy completes.
- `bus`  intf master modport  carries `req` (out), `gnt` (in), `addr` (out addr_t), `rdata` (in rdata_t), `wdata` (out wdata_t), `RE` (out), `WE` (out).

## Operation
- Uses a single clocked FSM. All bus outputs are registered.
- States:
  - IDLE
  - WAIT_GNT
  - READ
  - READ_WAIT
  - WRITE
  - PAUSE
  - DONE
- IDLE:
  - On `start` with `len`=0: go to DONE. `req` is never raised.
  - On `start` with `len`≠0: capture `src_base`, `dst_base` and `len`; clear word index `i` and burst count `b`; set `req`<=1; go to WAIT_GNT.
- WAIT_GNT:
  - Hold `RE`=`WE`=0.
  - On `gnt`=1: set `RE`<=1, `addr`<=src+i; go to READ.
- READ: `RE`<=0; go to READ_WAIT. The slave registers `rdata` at the edge that ends READ.
- READ_WAIT: `wdata`<=`rdata`, `addr`<=dst+i, `WE`<=1; go to WRITE.
- WRITE: `WE`<=0, `i`<=i+1, `b`<=b+1. Then the first matching rule applies:
  - If i+1=len: `req`<=0, go to DONE.
  - Else if b+1=MAX_BURST: `req`<=0, `b`<=0, go to PAUSE.
  - Else: `RE`<=1, `addr`<=src+i+1, go to READ.
- PAUSE: lasts exactly one cycle with `req`=0, which lets the arbiter clear `gnt`. Then `req`<=1 and go to WAIT_GNT.
- DONE: `done`=1 for one cycle; go to IDLE.
- Address arithmetic is 8-bit modulo 256, so it wraps from 0xFF to 0x00. Copy order is ascending; overlapping ranges get no special handling.
- `start` is ignored while `busy`. Input changes after capture have no effect.

## Timing
- Reset values: `req`=0, `RE`=0, `WE`=0, `addr`=0, `wdata`=0, `busy`=0, `done`=0, state=IDLE, `i`=0, `b`=0.
- Reset mid-copy: all of the above take effect immediately. The partial copy is abandoned and no `done` is issued.
- Uncontended copy, with `start` sampled at edge e0:
  - `gnt` rises at e1.
  - READ begins at e2.
  - Each word takes 3 cycles.
  - `done` is high between edges e(2+3·len) and e(3+3·len), plus 2 extra cycles for each PAUSE/regrant.
- `len`=0: `done` is high in the cycle after the `start` edge.
- `RE` and `WE` are never high in the same cycle. Each is high only while `gnt`=1.
- If `gnt` drops unexpectedly outside WAIT_GNT, the FSM continues anyway; the arbiter guarantees this never happens while `req`=1.

## Structure
- Add `dma_state_t` (enum of the seven states) to the shared `types` package.
- `addr_t`, `wdata_t` and `rdata_t` come from `types`.
- No sub-module; the FSM plus the `i`/`b` counters live in one process.
- Top level instantiates the block on a free master index, e.g. `bus.master[2].mport`.

## Test plan
- Reset and short copy:
  - Stimulus: hold `reset`; release; `start` with `len`=3, src=0x10, dst=0x90, slave0[0x10..0x12]=A1,B2,C3.
  - Response: after reset all outputs are 0; slave1 then holds A1,B2,C3 at 0x10..0x12 (dst 0x90 maps to slave1 offset 0x10); `done` at e11; `busy` is high e1..e11.
- Zero length: `start` with `len`=0 → `done` one cycle later; `req`, `RE` and `WE` never rise.
- Burst limit: `len`=6, `MAX_BURST`=4 → `req` low for exactly one cycle after the 4th WRITE, then regrant; all 6 words copied; `done` at e22.
- Contention: another master already holds `gnt`; `start` → DMA waits in WAIT_GNT with `RE`=`WE`=0 until that master drops `req`, then copies correctly.
- Address wrap: src=0xFE, `len`=3 → reads from 0xFE, 0xFF, 0x00 in that order.
- Reset mid-operation: assert `reset` during the 2nd WRITE → `req`, `RE` and `WE` go low immediately; no `done`; a new `start` after release copies correctly from word 0.
